// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-controller bus between the ID/EX/MEM stages and the controller
interface pipeline_hazard_ctrl_if #(parameter int XLEN = 64, parameter int CNT_W = 32);
  logic id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic id_use_rs1;
  logic id_use_rs2;
  logic ex_valid;
  logic [4:0] ex_rd;
  logic ex_mem_read;
  logic mem_busy;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic stall_if;
  logic stall_id;
  logic flush_id;
  logic bubble_ex;
  logic pc_load;
  logic [XLEN-1:0] pc_target;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_rd, ex_mem_read,
           mem_busy, redirect_valid, redirect_pc,
    input  stall_if, stall_id, flush_id, bubble_ex, pc_load, pc_target, ctrl_state,
           stall_cycles, flush_events
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_rd, ex_mem_read,
           mem_busy, redirect_valid, redirect_pc,
    output stall_if, stall_id, flush_id, bubble_ex, pc_load, pc_target, ctrl_state,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble sequencing for the in-order integer pipeline
module pipeline_hazard_ctrl #(
  parameter int XLEN = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic resetn,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEMWAIT = 2'd2} state_t;
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  state_t state, state_nx, ret, ret_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic load_use, accept, in_flush, hold;
  always_comb begin
    load_use = bus.id_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0)
             & ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) | (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
    accept = bus.redirect_valid & ~bus.mem_busy & (state != MEMWAIT);
    // leaving MEMWAIT behaves as the saved state in the same cycle
    in_flush = (state == MEMWAIT) ? (ret == FLUSH) : (state == FLUSH);
    hold = ~bus.mem_busy & ~accept & ~in_flush & load_use;
    bus.stall_if = bus.mem_busy | hold;
    bus.stall_id = bus.mem_busy | hold;
    bus.bubble_ex = hold;
    bus.flush_id = ~bus.mem_busy & (accept | in_flush);
    bus.pc_load = accept;
    bus.pc_target = accept ? bus.redirect_pc : {XLEN{1'b0}};
    bus.ctrl_state = state;
    bus.stall_cycles = stall_q;
    bus.flush_events = flush_q;
    state_nx = RUN;
    ret_nx = ret;
    cnt_nx = cnt;
    if (bus.mem_busy) begin
      state_nx = MEMWAIT;
      ret_nx = in_flush ? FLUSH : RUN;
    end else if (accept) begin
      state_nx = FLUSH_CYCLES == 1 ? RUN : FLUSH;
      cnt_nx = CW'(FLUSH_CYCLES - 1);
    end else if (in_flush) begin
      state_nx = cnt > 1 ? FLUSH : RUN;
      cnt_nx = cnt - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      ret <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      ret <= ret_nx;
      cnt <= cnt_nx;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (bus.stall_id && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (accept && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench, two DUTs (FLUSH_CYCLES 2/32-bit and 3/4-bit counters) on shared stimulus
module tb_pipeline_hazard_ctrl;
  typedef struct {
    logic iv; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic ev; logic [4:0] rd; logic mr; logic mb; logic rv; logic [63:0] pc;
  } in_t;
  typedef struct {
    logic [4:0] flags; logic [1:0] st; logic [63:0] pc; logic [63:0] sc; logic [63:0] fe;
  } exp_t;
  logic clk = 0;
  logic resetn = 0;
  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit frozen[2];
  int left[2];
  longint sc[2];
  longint fe[2];
  int fc[2] = '{2, 3};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'hF};
  pipeline_hazard_ctrl_if #(.XLEN(64), .CNT_W(32)) b0 ();
  pipeline_hazard_ctrl_if #(.XLEN(64), .CNT_W(4)) b1 ();
  pipeline_hazard_ctrl #(.XLEN(64), .FLUSH_CYCLES(2), .CNT_W(32)) dut0 (.clk(clk), .resetn(resetn), .bus(b0.slave));
  pipeline_hazard_ctrl #(.XLEN(64), .FLUSH_CYCLES(3), .CNT_W(4)) dut1 (.clk(clk), .resetn(resetn), .bus(b1.slave));
  assign b1.id_valid = b0.id_valid;
  assign b1.id_rs1 = b0.id_rs1;
  assign b1.id_rs2 = b0.id_rs2;
  assign b1.id_use_rs1 = b0.id_use_rs1;
  assign b1.id_use_rs2 = b0.id_use_rs2;
  assign b1.ex_valid = b0.ex_valid;
  assign b1.ex_rd = b0.ex_rd;
  assign b1.ex_mem_read = b0.ex_mem_read;
  assign b1.mem_busy = b0.mem_busy;
  assign b1.redirect_valid = b0.redirect_valid;
  assign b1.redirect_pc = b0.redirect_pc;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h t=%0t", n, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      frozen[k] = 0; left[k] = 0; sc[k] = 0; fe[k] = 0;
    end
  endtask

  // Reference: frozen while memory busy, 'left' = flush cycles still owed after this one
  task automatic model(int k, in_t x, output exp_t e);
    bit lu, acc;
    lu = x.iv && x.ev && x.mr && x.rd != 0 && ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
    acc = x.rv && !x.mb && !frozen[k];
    e.flags = x.mb ? 5'b11000 : acc ? 5'b00101 : left[k] > 0 ? 5'b00100 : lu ? 5'b11010 : 5'b00000;
    e.st = frozen[k] ? 2'd2 : left[k] > 0 ? 2'd1 : 2'd0;
    e.pc = acc ? x.pc : 64'd0;
    e.sc = 64'(sc[k]);
    e.fe = 64'(fe[k]);
    if (e.flags[3] && sc[k] < cmax[k]) sc[k]++;
    if (acc && fe[k] < cmax[k]) fe[k]++;
    if (x.mb) frozen[k] = 1;
    else begin
      frozen[k] = 0;
      if (acc) left[k] = fc[k] - 1;
      else if (left[k] > 0) left[k]--;
    end
  endtask

  function automatic in_t idle();
    in_t x;
    x = '{default: '0};
    return x;
  endfunction

  function automatic in_t ldu(logic [4:0] rd, logic u1);
    in_t x;
    x = idle();
    x.iv = 1; x.rs1 = 5; x.u1 = u1; x.ev = 1; x.rd = rd; x.mr = 1;
    return x;
  endfunction

  task automatic apply(in_t x, logic rst_n);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rst_n;
    b0.id_valid = x.iv; b0.id_rs1 = x.rs1; b0.id_rs2 = x.rs2;
    b0.id_use_rs1 = x.u1; b0.id_use_rs2 = x.u2; b0.ex_valid = x.ev;
    b0.ex_rd = x.rd; b0.ex_mem_read = x.mr; b0.mem_busy = x.mb;
    b0.redirect_valid = x.rv; b0.redirect_pc = x.pc;
    if (!rst_n) model_reset();
    model(0, x, e);
    q0.push_back(e);
    model(1, x, e);
    q1.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d0_flags", {59'd0, b0.stall_if, b0.stall_id, b0.flush_id, b0.bubble_ex, b0.pc_load}, {59'd0, e.flags});
      chk("d0_state", {62'd0, b0.ctrl_state}, {62'd0, e.st});
      chk("d0_pc_target", b0.pc_target, e.pc);
      chk("d0_stall_cycles", {32'd0, b0.stall_cycles}, e.sc);
      chk("d0_flush_events", {32'd0, b0.flush_events}, e.fe);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d1_flags", {59'd0, b1.stall_if, b1.stall_id, b1.flush_id, b1.bubble_ex, b1.pc_load}, {59'd0, e.flags});
      chk("d1_state", {62'd0, b1.ctrl_state}, {62'd0, e.st});
      chk("d1_pc_target", b1.pc_target, e.pc);
      chk("d1_stall_cycles", {60'd0, b1.stall_cycles}, e.sc);
      chk("d1_flush_events", {60'd0, b1.flush_events}, e.fe);
    end
  end

  initial begin
    in_t x;
    x = idle();
    b0.id_valid = 0; b0.id_rs1 = 0; b0.id_rs2 = 0; b0.id_use_rs1 = 0; b0.id_use_rs2 = 0;
    b0.ex_valid = 0; b0.ex_rd = 0; b0.ex_mem_read = 0; b0.mem_busy = 0;
    b0.redirect_valid = 0; b0.redirect_pc = 0;
    model_reset();
    apply(idle(), 0);
    apply(idle(), 1);
    apply(idle(), 1);
    apply(ldu(5, 1), 1);
    apply(idle(), 1);
    apply(ldu(0, 1), 1);
    apply(ldu(5, 0), 1);
    x = idle(); x.rv = 1; x.pc = 64'h8000_0040;
    apply(x, 1);
    repeat (3) apply(idle(), 1);
    apply(x, 1);
    x = idle(); x.mb = 1;
    repeat (3) apply(x, 1);
    repeat (3) apply(idle(), 1);
    x = ldu(5, 1); x.rv = 1; x.pc = 64'h1234;
    apply(x, 1);
    repeat (3) apply(idle(), 1);
    x = idle(); x.rv = 1; x.mb = 1; x.pc = 64'h5678;
    apply(x, 1);
    apply(idle(), 1);
    x = idle(); x.rv = 1; x.pc = 64'h40;
    apply(x, 1);
    apply(idle(), 0);
    apply(idle(), 1);
    for (int i = 0; i < 3000; i++) begin
      x.iv = 1'($urandom_range(0, 1)); x.ev = 1'($urandom_range(0, 1));
      x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3)); x.rd = 5'($urandom_range(0, 3));
      x.u1 = 1'($urandom_range(0, 1)); x.u2 = 1'($urandom_range(0, 1)); x.mr = 1'($urandom_range(0, 1));
      x.mb = $urandom_range(0, 99) < 15; x.rv = $urandom_range(0, 99) < 10;
      x.pc = {$urandom, $urandom};
      apply(x, $urandom_range(0, 999) != 0);
    end
    apply(idle(), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    chk("d1_stall_saturated", {60'd0, b1.stall_cycles}, 64'(sc[1]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
